// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - RV64 MEM stage: 64-bit ld/sd to byte-addressed memory with fixed access latency
module data_memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_fault
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [7:0]    mem [MEM_BYTES];
    logic [CW-1:0] cnt;
    logic          op_write;
    logic [AW-1:0] base;
    logic [63:0]   wdata_q;
    logic          request;
    logic          fault;
    logic [63:0]   rd_word;

    assign request  = mem_read | mem_write;
    assign fault    = (address[2:0] != 3'b000) || (address > MAX_ADDR);
    assign mem_busy = (state == WAIT) || ((state == IDLE) && request);

    // Little-endian doubleword view of the latched address
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem[base + AW'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            base      <= '0;
            wdata_q   <= '0;
            read_data <= '0;
            mem_done  <= 1'b0;
            mem_fault <= 1'b0;
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            mem_done  <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (fault) begin
                            mem_fault <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // A simultaneous ld+sd is serviced as a store
                            op_write <= mem_write;
                            base     <= address[AW-1:0];
                            wdata_q  <= write_data;
                            cnt      <= CW'(LATENCY - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (op_write) begin
                            for (int i = 0; i < 8; i++) begin
                                mem[base + AW'(i)] <= wdata_q[8*i +: 8];
                            end
                        end else begin
                            read_data <= rd_word;
                        end
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - randomized self-checking bench for data_memory_stage against a transaction model
module tb_data_memory_stage;

    localparam int MEM_BYTES = 1024;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_fault;

    data_memory_stage #(.MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_busy   (mem_busy),
        .mem_done   (mem_done),
        .mem_fault  (mem_fault)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;
    logic [7:0]  model_mem [MEM_BYTES];
    logic [63:0] exp_rd;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_fault;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("mem_busy",  64'(mem_busy),  64'(exp_busy));
            cmp("mem_done",  64'(mem_done),  64'(exp_done));
            cmp("mem_fault", 64'(mem_fault), 64'(exp_fault));
            cmp("read_data", read_data, exp_rd);
        end
    end

    function automatic bit is_fault(input logic [63:0] a);
        return (a % 8 != 0) || (a > 64'(MEM_BYTES - 8));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
        exp_rd = '0;
    endtask

    function automatic logic [63:0] model_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = model_mem[int'(a) + i];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        address   = {$urandom, $urandom};
        exp_busy  = 1'b0;
        tick();
    endtask

    // One full handshake; inputs are scrambled while in flight and in the DONE cycle
    task automatic access(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = d;
        exp_busy   = 1'b1;
        exp_done   = 1'b0;
        exp_fault  = 1'b0;
        tick();
        if (is_fault(a)) begin
            exp_busy  = 1'b0;
            exp_fault = 1'b1;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                address    = {$urandom, $urandom};
                write_data = {$urandom, $urandom};
                tick();
            end
            if (wr) begin
                for (int i = 0; i < 8; i++) model_mem[int'(a) + i] = d[8*i +: 8];
            end else begin
                exp_rd = model_word(a);
            end
            exp_busy = 1'b0;
            exp_done = 1'b1;
        end
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        address    = {$urandom, $urandom};
        write_data = {$urandom, $urandom};
        tick();
        exp_done  = 1'b0;
        exp_fault = 1'b0;
        exp_busy  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return 64'($urandom_range(0, 15) * 8 + $urandom_range(1, 7));
            1:       return 64'(MEM_BYTES);
            2:       return {1'b1, 31'($urandom), 32'($urandom & 32'hFFFF_FFF8)};
            3:       return 64'(MEM_BYTES - 8);
            default: return 64'($urandom_range(0, 15) * 8);
        endcase
    endfunction

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_fault  = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cmp("reset_read_data", read_data, 64'h0);
        cmp("reset_busy", 64'(mem_busy), 64'h0);
        cmp("reset_done", 64'(mem_done), 64'h0);
        cmp("reset_fault", 64'(mem_fault), 64'h0);
        reset = 1'b0;
        tick();

        access(1'b0, 1'b1, 64'd16, 64'h1122334455667788);
        access(1'b1, 1'b0, 64'd16, 64'h0);
        cmp("ld16_literal", read_data, 64'h1122334455667788);

        access(1'b1, 1'b0, 64'h13, 64'h0);
        cmp("misaligned_keeps_rd", read_data, 64'h1122334455667788);

        access(1'b0, 1'b1, 64'(MEM_BYTES - 8), 64'hCAFE_F00D_DEAD_BEEF);
        access(1'b1, 1'b0, 64'(MEM_BYTES - 8), 64'h0);
        cmp("ld_top_literal", read_data, 64'hCAFE_F00D_DEAD_BEEF);
        access(1'b1, 1'b0, 64'(MEM_BYTES), 64'h0);
        access(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h0BAD_0BAD_0BAD_0BAD);
        access(1'b1, 1'b0, 64'h0, 64'h0);
        cmp("high_addr_no_write", read_data, 64'h0);

        access(1'b1, 1'b0, 64'd16, 64'h0);
        access(1'b1, 1'b1, 64'd24, 64'hA5);
        cmp("both_keeps_rd", read_data, 64'h1122334455667788);
        access(1'b1, 1'b0, 64'd24, 64'h0);
        cmp("ld24_literal", read_data, 64'hA5);

        access(1'b0, 1'b1, 64'd8, 64'h0123_4567_89AB_CDEF);
        mem_write  = 1'b1;
        address    = 64'd8;
        write_data = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_busy   = 1'b1;
        tick();
        reset     = 1'b1;
        mem_write = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
        exp_busy = 1'b0;
        tick();
        access(1'b1, 1'b0, 64'd8, 64'h0);
        cmp("ld8_after_reset", read_data, 64'h0);

        for (int n = 0; n < 300; n++) begin
            int op;
            if ($urandom_range(0, 4) == 0) idle_cycle();
            op = $urandom_range(1, 3);
            access(op[0], op[1], rand_addr(), {$urandom, $urandom});
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
